// File: rtl/branch_resolve_ctrl.sv
// RV32I execute-stage branch/jump resolver: evaluates the condition, sequences redirect and flush.
// Optional build macro BRANCH_PERF_CNT_EN adds branch/taken performance counters.
module branch_resolve_ctrl #(
    parameter int REG_WIDTH    = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [1:0]           op_kind,
    input  logic [2:0]           op_funct3,
    input  logic [REG_WIDTH-1:0] op_pc,
    input  logic [REG_WIDTH-1:0] op_imm,
    input  logic [REG_WIDTH-1:0] op_rs1,
    input  logic [REG_WIDTH-1:0] op_rs2,
    output logic [REG_WIDTH-1:0] cmp_rs1,
    output logic [REG_WIDTH-1:0] cmp_rs2,
    output logic                 cmp_BrUn,
    input  logic                 cmp_BrEq,
    input  logic                 cmp_BrLT,
    output logic                 res_valid,
    output logic                 res_taken,
    output logic                 res_illegal,
    output logic                 res_misalign,
    output logic                 redirect_valid,
    output logic [REG_WIDTH-1:0] redirect_pc,
    input  logic                 redirect_ready,
    output logic                 flush
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_branches,
    output logic [31:0]          perf_taken
`endif
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_REDIRECT,
        S_FLUSH
    } state_t;

    state_t               r_state;
    logic [1:0]           r_kind;
    logic [2:0]           r_funct3;
    logic [REG_WIDTH-1:0] r_pc;
    logic [REG_WIDTH-1:0] r_imm;
    logic [REG_WIDTH-1:0] r_rs1;
    logic [REG_WIDTH-1:0] r_rs2;
    logic [REG_WIDTH-1:0] r_redirect_pc;
    logic [CNT_W-1:0]     r_flush_cnt;

    logic                 w_eval;
    logic                 w_is_branch;
    logic                 w_is_jalr;
    logic                 w_illegal;
    logic                 w_cond;
    logic                 w_taken;
    logic                 w_misalign;
    logic [REG_WIDTH-1:0] w_sum;
    logic [REG_WIDTH-1:0] w_target;

    assign w_eval      = (r_state == S_EVAL);
    assign w_is_branch = (r_kind == 2'b00);
    assign w_is_jalr   = (r_kind == 2'b10);
    // funct3 010/011 are the only undefined branch encodings
    assign w_illegal   = (r_kind == 2'b11) || (w_is_branch && (r_funct3[2:1] == 2'b01));

    // funct3[2] picks LT over EQ, funct3[0] inverts the sense
    assign w_cond      = (r_funct3[2] ? cmp_BrLT : cmp_BrEq) ^ r_funct3[0];
    assign w_taken     = (w_is_branch ? w_cond : 1'b1) & ~w_illegal;

    assign w_sum       = (w_is_jalr ? r_rs1 : r_pc) + r_imm;
    assign w_target    = {w_sum[REG_WIDTH-1:1], w_sum[0] & ~w_is_jalr};
    assign w_misalign  = w_taken & (w_target[1:0] != 2'b00);

    assign op_ready       = (r_state == S_IDLE);
    assign cmp_rs1        = r_rs1;
    assign cmp_rs2        = r_rs2;
    assign cmp_BrUn       = r_funct3[1];
    assign res_valid      = w_eval;
    assign res_taken      = w_eval & w_taken;
    assign res_illegal    = w_eval & w_illegal;
    assign res_misalign   = w_eval & w_misalign;
    assign redirect_valid = (r_state == S_REDIRECT);
    assign redirect_pc    = r_redirect_pc;
    assign flush          = (r_state == S_REDIRECT) || (r_state == S_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_kind        <= '0;
            r_funct3      <= '0;
            r_pc          <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_redirect_pc <= '0;
            r_flush_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_kind   <= op_kind;
                        r_funct3 <= op_funct3;
                        r_pc     <= op_pc;
                        r_imm    <= op_imm;
                        r_rs1    <= op_rs1;
                        r_rs2    <= op_rs2;
                        r_state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_taken && !w_misalign) begin
                        r_redirect_pc <= w_target;
                        r_state       <= S_REDIRECT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        if (FLUSH_CYCLES == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_flush_cnt <= CNT_W'(FLUSH_CYCLES);
                            r_state     <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt - 1'b1;
                    if (r_flush_cnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches <= '0;
            perf_taken    <= '0;
        end else if (w_eval && w_is_branch && !w_illegal) begin
            perf_branches <= perf_branches + 32'd1;
            if (w_taken) begin
                perf_taken <= perf_taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: random ops against a rule-level reference model.
// Perf counter checks are compiled in when BRANCH_PERF_CNT_EN is defined.
module tb_branch_resolve_ctrl;

    localparam int W  = 32;
    localparam int FC = 2;

    logic         clk;
    logic         rst;
    logic         op_valid;
    logic         op_ready;
    logic [1:0]   op_kind;
    logic [2:0]   op_funct3;
    logic [W-1:0] op_pc, op_imm, op_rs1, op_rs2;
    logic [W-1:0] cmp_rs1, cmp_rs2;
    logic         cmp_BrUn, cmp_BrEq, cmp_BrLT;
    logic         res_valid, res_taken, res_illegal, res_misalign;
    logic         redirect_valid;
    logic [W-1:0] redirect_pc;
    logic         redirect_ready;
    logic         flush;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0]  perf_branches, perf_taken;
`endif

    // Shared comparator the controller drives
    assign cmp_BrEq = (cmp_rs1 == cmp_rs2);
    assign cmp_BrLT = cmp_BrUn ? (cmp_rs1 < cmp_rs2) : ($signed(cmp_rs1) < $signed(cmp_rs2));

    branch_resolve_ctrl #(.REG_WIDTH(W), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind), .op_funct3(op_funct3),
        .op_pc(op_pc), .op_imm(op_imm), .op_rs1(op_rs1), .op_rs2(op_rs2),
        .cmp_rs1(cmp_rs1), .cmp_rs2(cmp_rs2), .cmp_BrUn(cmp_BrUn),
        .cmp_BrEq(cmp_BrEq), .cmp_BrLT(cmp_BrLT),
        .res_valid(res_valid), .res_taken(res_taken), .res_illegal(res_illegal),
        .res_misalign(res_misalign),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush(flush)
`ifdef BRANCH_PERF_CNT_EN
        , .perf_branches(perf_branches), .perf_taken(perf_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         taken, illegal, misalign, redir;
        logic         is_br;
        logic         bru;
        logic [W-1:0] tgt, rs1, rs2;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    bit           mon_en = 0;
    bit           acc_prev = 0;
    bit           pend_redir = 0;
    logic [W-1:0] pend_pc = '0;
    int           flush_left = 0;
    int           m_branches = 0;
    int           m_taken = 0;
    int           rr_ctl = 0;   // 0 random, 1 force low, 2 force high

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] kind, input logic [2:0] f3,
                                   input logic [W-1:0] pc, input logic [W-1:0] imm,
                                   input logic [W-1:0] rs1, input logic [W-1:0] rs2);
        exp_t e;
        bit   cond;
        cond = 1'b0;
        case (f3)
            3'd0: cond = (rs1 == rs2);
            3'd1: cond = (rs1 != rs2);
            3'd4: cond = ($signed(rs1) < $signed(rs2));
            3'd5: cond = ($signed(rs1) >= $signed(rs2));
            3'd6: cond = (rs1 < rs2);
            3'd7: cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
        e.illegal  = (kind == 2'd3) || (kind == 2'd0 && (f3 == 3'd2 || f3 == 3'd3));
        e.is_br    = (kind == 2'd0) && !e.illegal;
        e.taken    = e.illegal ? 1'b0 : ((kind == 2'd0) ? cond : 1'b1);
        e.tgt      = (kind == 2'd2) ? ((rs1 + imm) & ~32'd1) : (pc + imm);
        e.misalign = e.taken && (e.tgt % 4 != 0);
        e.redir    = e.taken && !e.misalign;
        e.bru      = (f3 == 3'd6 || f3 == 3'd7);
        e.rs1      = rs1;
        e.rs2      = rs2;
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            bit   exp_res, exp_ready, new_redir;
            new_redir = 0;
            exp_res   = acc_prev;
            exp_ready = !(exp_res || pend_redir || flush_left > 0);
            check("res_valid", res_valid, exp_res);
            if (exp_res) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got result with no issued op at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("res_taken", res_taken, e.taken);
                    check("res_illegal", res_illegal, e.illegal);
                    check("res_misalign", res_misalign, e.misalign);
                    if (e.is_br) begin
                        check("cmp_BrUn", cmp_BrUn, e.bru);
                        check("cmp_rs1", cmp_rs1, e.rs1);
                        check("cmp_rs2", cmp_rs2, e.rs2);
                        m_branches++;
                        if (e.taken) m_taken++;
                    end
                    new_redir = e.redir;
                end
            end
            check("redirect_valid", redirect_valid, pend_redir);
            if (pend_redir) check("redirect_pc", redirect_pc, pend_pc);
            check("flush", flush, pend_redir || flush_left > 0);
            check("op_ready", op_ready, exp_ready);
            if (flush_left > 0) flush_left--;
            if (pend_redir && redirect_ready) begin
                pend_redir = 0;
                flush_left = FC;
            end
            if (new_redir) begin
                pend_redir = 1;
                pend_pc    = e.tgt;
            end
            acc_prev = exp_ready && op_valid;
        end
    end

    initial begin
        redirect_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rr_ctl)
                1: redirect_ready = 1'b0;
                2: redirect_ready = 1'b1;
                default: redirect_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    task automatic clear_model();
        sb.delete();
        acc_prev   = 0;
        pend_redir = 0;
        flush_left = 0;
        m_branches = 0;
        m_taken    = 0;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [2:0] f3, input logic [W-1:0] pc,
                         input logic [W-1:0] imm, input logic [W-1:0] rs1, input logic [W-1:0] rs2);
        bit ok;
        ok        = 0;
        op_valid  = 1'b1;
        op_kind   = kind;
        op_funct3 = f3;
        op_pc     = pc;
        op_imm    = imm;
        op_rs1    = rs1;
        op_rs2    = rs2;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (op_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            sb.push_back(model(kind, f3, pc, imm, rs1, rs2));
        end else begin
            total++;
            bad++;
            $display("FAIL issue_timeout: op_ready=%b required 1 within 100 cycles", op_ready);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (op_ready && !flush && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: op_ready=%b flush=%b required idle", op_ready, flush);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_mid(input bit in_flush);
        wait_idle();
        mon_en = 0;
        rr_ctl = 1;
        op_valid = 1'b1; op_kind = 2'd0; op_funct3 = 3'd0;
        op_pc = 32'h100; op_imm = 32'h20; op_rs1 = 32'h5; op_rs2 = 32'h5;
        @(posedge clk); #1;
        op_valid = 1'b0;
        check("rm_eval_res", res_valid, 1'b1);
        @(posedge clk); #1;
        check("rm_redirect", redirect_valid, 1'b1);
        if (in_flush) begin
            rr_ctl = 2;
            @(posedge clk); #1;
            rr_ctl = 1;
            check("rm_in_flush", flush, 1'b1);
            check("rm_flush_no_redir", redirect_valid, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rm_flush0", flush, 1'b0);
        check("rm_redir0", redirect_valid, 1'b0);
        check("rm_res0", res_valid, 1'b0);
        check("rm_ready1", op_ready, 1'b1);
        check("rm_rpc0", redirect_pc, 32'h0);
        check("rm_cmp0", cmp_rs1, 32'h0);
`ifdef BRANCH_PERF_CNT_EN
        check("rm_perf_br0", perf_branches, 32'h0);
        check("rm_perf_tk0", perf_taken, 32'h0);
`endif
        @(posedge clk); #1;
        check("rm_no_res", res_valid, 1'b0);
        clear_model();
        rr_ctl = 0;
        mon_en = 1;
    endtask

    initial begin
        logic [1:0]   k;
        logic [W-1:0] a, b, im;
        logic [11:0]  s;
        rst = 1'b1; op_valid = 1'b0; op_kind = '0; op_funct3 = '0;
        op_pc = '0; op_imm = '0; op_rs1 = '0; op_rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", op_ready, 1'b1);
        check("rst_res", res_valid, 1'b0);
        check("rst_redir", redirect_valid, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_rpc", redirect_pc, 32'h0);
        check("rst_cmp1", cmp_rs1, 32'h0);
        check("rst_cmp2", cmp_rs2, 32'h0);
        check("rst_brun", cmp_BrUn, 1'b0);
        mon_en = 1;

        rr_ctl = 2;
        issue(2'd0, 3'd0, 32'h100, 32'h20, 32'h5, 32'h5);              // BEQ taken -> 0x120
        issue(2'd0, 3'd4, 32'h200, 32'h40, 32'hFFFFFFFF, 32'h1);       // BLT taken
        issue(2'd0, 3'd6, 32'h200, 32'h40, 32'hFFFFFFFF, 32'h1);       // BLTU not taken
        issue(2'd0, 3'd1, 32'h300, 32'h8, 32'h7, 32'h7);               // BNE not taken
        issue(2'd2, 3'd0, 32'h400, 32'h0, 32'h203, 32'h0);             // JALR -> 0x202 misaligned
        issue(2'd2, 3'd0, 32'h400, 32'h3, 32'h205, 32'h0);             // JALR -> 0x208
        issue(2'd1, 3'd0, 32'h100, 32'h2, 32'h0, 32'h0);               // JAL misaligned
        issue(2'd0, 3'd2, 32'h100, 32'h20, 32'h5, 32'h5);              // bad funct3
        issue(2'd3, 3'd0, 32'h100, 32'h20, 32'h5, 32'h5);              // reserved kind
        issue(2'd1, 3'd0, 32'hFFFFFFF0, 32'h20, 32'h0, 32'h0);         // target wraps to 0x10
        wait_idle();
        rr_ctl = 1;
        issue(2'd0, 3'd5, 32'h500, 32'h100, 32'h3, 32'h3);             // BGE taken, ready held low
        repeat (7) @(posedge clk);
        #1;
        rr_ctl = 2;
        wait_idle();
        rr_ctl = 0;

        for (int i = 0; i < 300; i++) begin
            if (i == 150) rst_mid(1'b0);
            if (i == 200) rst_mid(1'b1);
            case ($urandom_range(0, 12))
                0, 1, 2, 3, 4, 5, 6, 7: k = 2'd0;
                8, 9:   k = 2'd1;
                10, 11: k = 2'd2;
                default: k = 2'd3;
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a + 32'd1;
                2: b = a - 32'd1;
                default: b = $urandom;
            endcase
            s  = 12'($urandom);
            im = {{20{s[11]}}, s};
            if ($urandom_range(0, 3) != 0) im = im & ~32'd3;
            issue(k, 3'($urandom_range(0, 7)), $urandom & ~32'd3, im, a, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
`ifdef BRANCH_PERF_CNT_EN
        check("perf_branches", perf_branches, m_branches);
        check("perf_taken", perf_taken, m_taken);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
